rgb_frame_loader: RTL and testbench

RGB_FRAME_LOADER -- requirements
Module: rgb_frame_loader

---
 rtl/rgb_frame_loader.sv | 102 ++++++++++
 tb/tb_rgb_frame_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_frame_loader.sv
// rtl/rgb_frame_loader.sv - assembles 4-byte header/R/G/B frames into mask-stage commands
// A frame stalled mid-way for TIMEOUT cycles is dropped and flagged on FrameErr.
module rgb_frame_loader #(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        Mode,
  output logic [3:0]  Address,
  output logic [23:0] RGBin,
  output logic [2:0]  Op,
  output logic        CmdValid,
  output logic        FrameErr,
  output logic [7:0]  CmdCount
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_R = 3'd1,
    GET_G = 3'd2,
    GET_B = 3'd3,
    ISSUE = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] hdr;
  logic [7:0] r_byte;
  logic [7:0] g_byte;
  logic [7:0] stall;
  logic       xfer;
  logic       in_frame;
  logic       stall_limit;

  assign ByteReady   = (state != ISSUE) && !RST;
  assign xfer        = ByteValid && ByteReady;
  assign in_frame    = (state == GET_R) || (state == GET_G) || (state == GET_B);
  assign stall_limit = (stall == 8'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      hdr      <= '0;
      r_byte   <= '0;
      g_byte   <= '0;
      stall    <= '0;
      Mode     <= 1'b1;
      Address  <= '0;
      RGBin    <= '0;
      Op       <= '0;
      CmdValid <= 1'b0;
      FrameErr <= 1'b0;
      CmdCount <= '0;
    end else begin
      CmdValid <= 1'b0;
      FrameErr <= 1'b0;
      if (xfer) begin
        stall <= '0;
        case (state)
          IDLE: begin
            hdr   <= ByteIn;
            state <= GET_R;
          end
          GET_R: begin
            r_byte <= ByteIn;
            state  <= GET_G;
          end
          GET_G: begin
            g_byte <= ByteIn;
            state  <= GET_B;
          end
          GET_B: begin
            // Command fields only ever change here, so partial frames never leak out.
            Mode     <= hdr[7];
            Op       <= hdr[6:4];
            Address  <= hdr[3:0];
            RGBin    <= {r_byte, g_byte, ByteIn};
            CmdValid <= 1'b1;
            CmdCount <= CmdCount + 8'd1;
            state    <= ISSUE;
          end
          default: state <= IDLE;
        endcase
      end else if (in_frame) begin
        if (stall_limit) begin
          state    <= IDLE;
          stall    <= '0;
          FrameErr <= 1'b1;
        end else begin
          stall <= stall + 8'd1;
        end
      end else if (state == ISSUE) begin
        state <= IDLE;
      end else if (state != IDLE) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_rgb_frame_loader.sv
// tb/tb_rgb_frame_loader.sv - randomized and directed checks of rgb_frame_loader against a frame model
module tb_rgb_frame_loader;
  localparam int TO = 15;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  ByteIn = 8'h00;
  logic        ByteValid = 1'b0;
  logic        ByteReady;
  logic        Mode;
  logic [3:0]  Address;
  logic [23:0] RGBin;
  logic [2:0]  Op;
  logic        CmdValid;
  logic        FrameErr;
  logic [7:0]  CmdCount;

  int checks = 0;
  int errors = 0;

  rgb_frame_loader #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady),
    .Mode(Mode), .Address(Address), .RGBin(RGBin), .Op(Op), .CmdValid(CmdValid),
    .FrameErr(FrameErr), .CmdCount(CmdCount)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: a count of collected bytes plus a buffer, one-cycle issue gap.
  int         m_n = 0;
  bit         m_issue = 0;
  int         m_stall = 0;
  logic [7:0] m_buf [0:2];
  logic       m_mode = 1'b1;
  logic [3:0] m_addr = '0;
  logic [2:0] m_op = '0;
  logic [23:0] m_rgb = '0;
  logic       m_cv = 1'b0;
  logic       m_fe = 1'b0;
  logic [7:0] m_cnt = '0;
  int         cyc = 0;
  int         last_cv = -1;
  int         cv_seen = 0;
  bit         b2b = 0;

  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      m_n = 0; m_issue = 0; m_stall = 0;
      m_mode = 1'b1; m_addr = '0; m_op = '0; m_rgb = '0;
      m_cv = 1'b0; m_fe = 1'b0; m_cnt = '0;
    end else begin
      m_cv = 1'b0;
      m_fe = 1'b0;
      if (m_issue) begin
        m_issue = 0;
      end else if (ByteValid) begin
        m_stall = 0;
        if (m_n == 3) begin
          m_mode = m_buf[0][7];
          m_op   = m_buf[0][6:4];
          m_addr = m_buf[0][3:0];
          m_rgb  = {m_buf[1], m_buf[2], ByteIn};
          m_cv   = 1'b1;
          m_cnt  = m_cnt + 8'd1;
          m_issue = 1;
          m_n = 0;
        end else begin
          m_buf[m_n] = ByteIn;
          m_n++;
        end
      end else if (m_n > 0) begin
        if (m_stall == TO - 1) begin
          m_n = 0;
          m_stall = 0;
          m_fe = 1'b1;
        end else begin
          m_stall++;
        end
      end
    end
    #1;
    chk("ByteReady", ByteReady, !m_issue && !RST);
    chk("CmdValid", CmdValid, m_cv);
    chk("FrameErr", FrameErr, m_fe);
    chk("Mode", Mode, m_mode);
    chk("Address", Address, m_addr);
    chk("Op", Op, m_op);
    chk("RGBin", RGBin, m_rgb);
    chk("CmdCount", CmdCount, m_cnt);
    chk("cv_fe_exclusive", CmdValid & FrameErr, 1'b0);
    if (b2b && m_cv) begin
      if (last_cv >= 0) chk("b2b_gap", cyc - last_cv, 5);
      last_cv = cyc;
      cv_seen++;
    end
  end

  task automatic send_byte(input logic [7:0] b, output int waits);
    bit rdy;
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      ByteValid = 1'b1;
      ByteIn = b;
      rdy = ByteReady;
      @(posedge CLK);
      if (rdy) return;
      waits++;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: byte 0x%0h not accepted within 20 cycles", b);
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int w;
    send_byte(h, w);
    send_byte(r, w);
    send_byte(g, w);
    send_byte(b, w);
  endtask

  task automatic check_cmd(input string name, input logic mode, input logic [2:0] op,
                           input logic [3:0] addr, input logic [23:0] rgb, input logic [7:0] cnt);
    #1;
    chk({name, "_cv"}, CmdValid, 1'b1);
    chk({name, "_mode"}, Mode, mode);
    chk({name, "_op"}, Op, op);
    chk({name, "_addr"}, Address, addr);
    chk({name, "_rgb"}, RGBin, rgb);
    chk({name, "_cnt"}, CmdCount, cnt);
  endtask

  task automatic idle_count(input int n, output int fe_n, output int fe_at);
    fe_n = 0;
    fe_at = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge CLK);
      ByteValid = 1'b0;
      @(posedge CLK);
      #1;
      if (FrameErr) begin
        fe_n++;
        fe_at = i;
      end
    end
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_rdy"}, ByteReady, 1'b0);
    chk({name, "_mode"}, Mode, 1'b1);
    chk({name, "_addr"}, Address, 4'h0);
    chk({name, "_op"}, Op, 3'h0);
    chk({name, "_rgb"}, RGBin, 24'h0);
    chk({name, "_cv"}, CmdValid, 1'b0);
    chk({name, "_fe"}, FrameErr, 1'b0);
    chk({name, "_cnt"}, CmdCount, 8'h0);
  endtask

  initial begin
    int w;
    int fe_n;
    int fe_at;
    int seg;

    repeat (3) @(posedge CLK);
    #1 check_reset_values("reset");
    @(posedge CLK);
    #2 RST = 1'b0;

    // Plain write command; first byte must go on the first edge after release.
    send_byte(8'h0A, w);
    chk("first_xfer_waits", w, 0);
    send_byte(8'h81, w);
    send_byte(8'hC3, w);
    send_byte(8'h42, w);
    check_cmd("f031", 1'b0, 3'd0, 4'hA, 24'h81C342, 8'd1);

    // Valid held through ISSUE: next header waits exactly one cycle.
    send_frame(8'h9A, 8'h81, 8'hC3, 8'h42);
    check_cmd("f032", 1'b1, 3'd1, 4'hA, 24'h81C342, 8'd2);
    send_byte(8'h0A, w);
    chk("issue_wait", w, 1);
    send_byte(8'h55, w);
    send_byte(8'h66, w);
    send_byte(8'h77, w);
    check_cmd("f032b", 1'b0, 3'd0, 4'hA, 24'h556677, 8'd3);

    // Stall timeout after header+R.
    send_byte(8'hF5, w);
    send_byte(8'h11, w);
    idle_count(TO, fe_n, fe_at);
    chk("timeout_pulses", fe_n, 1);
    chk("timeout_cycle", fe_at, TO);
    chk("timeout_keep_rgb", RGBin, 24'h556677);
    chk("timeout_keep_addr", Address, 4'hA);
    chk("timeout_keep_cnt", CmdCount, 8'd3);
    send_frame(8'h2B, 8'h01, 8'h02, 8'h03);
    check_cmd("after_abort", 1'b0, 3'd2, 4'hB, 24'h010203, 8'd4);

    // Byte on the last stall cycle rescues the frame.
    send_byte(8'hF5, w);
    send_byte(8'h11, w);
    idle_count(TO - 1, fe_n, fe_at);
    chk("rescue_no_fe_idle", fe_n, 0);
    send_byte(8'hC0, w);
    #1 chk("rescue_no_fe_edge", FrameErr, 1'b0);
    send_byte(8'hD0, w);
    check_cmd("rescue", 1'b1, 3'd7, 4'h5, 24'h11C0D0, 8'd5);

    // Asynchronous reset mid-frame.
    send_byte(8'h12, w);
    send_byte(8'h34, w);
    @(negedge CLK);
    ByteValid = 1'b0;
    #2 RST = 1'b1;
    #1 check_reset_values("async_rst");
    @(posedge CLK);
    #2 RST = 1'b0;
    send_frame(8'h3F, 8'hFF, 8'h00, 8'hAA);
    check_cmd("f035", 1'b0, 3'd3, 4'hF, 24'hFF00AA, 8'd1);

    // 256 back-to-back frames wrap CmdCount at a steady 5-cycle rate.
    @(negedge CLK);
    ByteValid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    b2b = 1;
    last_cv = -1;
    cv_seen = 0;
    for (int f = 0; f < 256; f++)
      send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    #1;
    chk("wrap_cnt", CmdCount, 8'd0);
    chk("wrap_cv_seen", cv_seen, 256);
    b2b = 0;

    // Random traffic with dense, sparse, silent and saturated segments.
    seg = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      if (i % 40 == 0) seg = int'($urandom_range(0, 3));
      if (RST) RST = 1'b0;
      else if ($urandom_range(0, 299) == 0) RST = 1'b1;
      ByteIn = 8'($urandom);
      case (seg)
        0: ByteValid = ($urandom_range(0, 99) < 90);
        1: ByteValid = ($urandom_range(0, 99) < 40);
        2: ByteValid = 1'b0;
        default: ByteValid = 1'b1;
      endcase
    end
    @(negedge CLK);
    ByteValid = 1'b0;
    RST = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
